// File: rtl/vga_pattern_gen_pkg.sv
// Shared VGA timing constants and pattern codes, used by the pattern source
// and by the downstream sync/porch stage.
package vga_pattern_gen_pkg;

    localparam int CNT_W = 10;

    localparam int TOTAL_COLS  = 800;
    localparam int TOTAL_ROWS  = 525;
    localparam int ACTIVE_COLS = 640;
    localparam int ACTIVE_ROWS = 480;

    localparam int H_FRONT_PORCH = 16;
    localparam int H_SYNC_WIDTH  = 96;
    localparam int H_BACK_PORCH  = 48;
    localparam int V_FRONT_PORCH = 10;
    localparam int V_SYNC_WIDTH  = 2;
    localparam int V_BACK_PORCH  = 33;

    localparam int NUM_BARS     = 8;
    localparam int MOVING_BAR_W = 16;

    localparam logic [2:0] PAT_BLACK   = 3'd0;
    localparam logic [2:0] PAT_WHITE   = 3'd1;
    localparam logic [2:0] PAT_RED     = 3'd2;
    localparam logic [2:0] PAT_BARS    = 3'd3;
    localparam logic [2:0] PAT_CHECKER = 3'd4;
    localparam logic [2:0] PAT_BORDER  = 3'd5;
    localparam logic [2:0] PAT_MOVING  = 3'd6;
    localparam logic [2:0] PAT_RSVD    = 3'd7;

endpackage

// File: rtl/vga_pixel_counter.sv
// Free-running column/row counters with end-of-line and end-of-frame strobes;
// reusable by any video source running on the pixel clock.
module vga_pixel_counter
    import vga_pattern_gen_pkg::*;
#(
    parameter int TOTAL_COLS = vga_pattern_gen_pkg::TOTAL_COLS,
    parameter int TOTAL_ROWS = vga_pattern_gen_pkg::TOTAL_ROWS
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    output logic [CNT_W-1:0] o_Col,
    output logic [CNT_W-1:0] o_Row,
    output logic             o_Line_End,
    output logic             o_Frame_End
);

    logic [CNT_W-1:0] r_Col;
    logic [CNT_W-1:0] r_Row;

    assign o_Line_End  = (r_Col == CNT_W'(TOTAL_COLS - 1));
    assign o_Frame_End = o_Line_End && (r_Row == CNT_W'(TOTAL_ROWS - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Col <= '0;
            r_Row <= '0;
        end else if (o_Line_End) begin
            r_Col <= '0;
            r_Row <= o_Frame_End ? '0 : r_Row + 1'b1;
        end else begin
            r_Col <= r_Col + 1'b1;
        end
    end

    assign o_Col = r_Col;
    assign o_Row = r_Row;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern video source: pixel counters, frame-latched pattern select,
// colour-bar tracker, moving-bar position and one output register stage.
module vga_pattern_gen
    import vga_pattern_gen_pkg::*;
#(
    parameter int COLOR_BITS  = 3,
    parameter int TOTAL_COLS  = vga_pattern_gen_pkg::TOTAL_COLS,
    parameter int TOTAL_ROWS  = vga_pattern_gen_pkg::TOTAL_ROWS,
    parameter int ACTIVE_COLS = vga_pattern_gen_pkg::ACTIVE_COLS,
    parameter int ACTIVE_ROWS = vga_pattern_gen_pkg::ACTIVE_ROWS,
    parameter int BAR_STEP    = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [2:0]            i_Pattern_Sel,
    output logic [CNT_W-1:0]      o_Col_Count,
    output logic [CNT_W-1:0]      o_Row_Count,
    output logic                  o_Frame_Start,
    output logic [COLOR_BITS-1:0] o_Red_Video,
    output logic [COLOR_BITS-1:0] o_Grn_Video,
    output logic [COLOR_BITS-1:0] o_Blu_Video
);

    localparam int BAR_W = ACTIVE_COLS / NUM_BARS;
    localparam int SUB_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic [CNT_W-1:0] r_Col;
    logic [CNT_W-1:0] r_Row;
    logic             w_Line_End;
    logic             w_Frame_End;

    logic [2:0]       r_Pattern;
    logic [CNT_W-1:0] r_Bar_X;
    logic [2:0]       r_Bar_Idx;
    logic [SUB_W-1:0] r_Bar_Sub;

    logic [CNT_W:0]   w_Bar_X_Next;
    logic [CNT_W:0]   w_Bar_End;
    logic             w_Active;
    logic             w_Border;
    logic             w_In_Bar;
    logic [2:0]       w_Rgb;

    vga_pixel_counter #(
        .TOTAL_COLS (TOTAL_COLS),
        .TOTAL_ROWS (TOTAL_ROWS)
    ) u_pixel_counter (
        .i_Clk       (i_Clk),
        .i_Rst       (i_Rst),
        .o_Col       (r_Col),
        .o_Row       (r_Row),
        .o_Line_End  (w_Line_End),
        .o_Frame_End (w_Frame_End)
    );

    // Bar index follows r_Col/BAR_W by counting, so no divider is needed.
    always_ff @(posedge i_Clk) begin
        if (i_Rst || w_Line_End) begin
            r_Bar_Idx <= '0;
            r_Bar_Sub <= '0;
        end else if (r_Bar_Sub == SUB_W'(BAR_W - 1)) begin
            r_Bar_Idx <= r_Bar_Idx + 3'd1;
            r_Bar_Sub <= '0;
        end else begin
            r_Bar_Sub <= r_Bar_Sub + 1'b1;
        end
    end

    assign w_Bar_X_Next = {1'b0, r_Bar_X} + (CNT_W + 1)'(BAR_STEP);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Pattern <= PAT_BLACK;
            r_Bar_X   <= '0;
        end else if (w_Frame_End) begin
            r_Pattern <= i_Pattern_Sel;
            if (w_Bar_X_Next >= (CNT_W + 1)'(ACTIVE_COLS))
                r_Bar_X <= CNT_W'(w_Bar_X_Next - (CNT_W + 1)'(ACTIVE_COLS));
            else
                r_Bar_X <= CNT_W'(w_Bar_X_Next);
        end
    end

    assign w_Active  = (r_Col < CNT_W'(ACTIVE_COLS)) && (r_Row < CNT_W'(ACTIVE_ROWS));
    assign w_Border  = (r_Col == '0) || (r_Col == CNT_W'(ACTIVE_COLS - 1)) ||
                       (r_Row == '0) || (r_Row == CNT_W'(ACTIVE_ROWS - 1));
    // The bar is clipped at the right edge rather than wrapping to column 0.
    assign w_Bar_End = {1'b0, r_Bar_X} + (CNT_W + 1)'(MOVING_BAR_W);
    assign w_In_Bar  = (r_Col >= r_Bar_X) && ({1'b0, r_Col} < w_Bar_End);

    // NOTE: w_Rgb gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_Rgb = 3'b000;
        case (r_Pattern)
            PAT_WHITE:   w_Rgb = 3'b111;
            PAT_RED:     w_Rgb = 3'b100;
            PAT_BARS:    w_Rgb = r_Bar_Idx;
            PAT_CHECKER: w_Rgb = {3{r_Col[5] ^ r_Row[5]}};
            PAT_BORDER:  w_Rgb = {3{w_Border}};
            PAT_MOVING:  w_Rgb = {3{w_In_Bar}};
            default:     w_Rgb = 3'b000;
        endcase
        if (!w_Active)
            w_Rgb = 3'b000;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Col_Count   <= '0;
            o_Row_Count   <= '0;
            o_Frame_Start <= 1'b0;
            o_Red_Video   <= '0;
            o_Grn_Video   <= '0;
            o_Blu_Video   <= '0;
        end else begin
            o_Col_Count   <= r_Col;
            o_Row_Count   <= r_Row;
            o_Frame_Start <= (r_Col == '0) && (r_Row == '0);
            o_Red_Video   <= {COLOR_BITS{w_Rgb[2]}};
            o_Grn_Video   <= {COLOR_BITS{w_Rgb[1]}};
            o_Blu_Video   <= {COLOR_BITS{w_Rgb[0]}};
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen on a reduced raster so that many frames
// fit in a short run; expected pixels are hand-computed for that geometry.
module tb_vga_pattern_gen;

    localparam int TC    = 100;
    localparam int TR    = 38;
    localparam int AC    = 96;
    localparam int AR    = 36;
    localparam int STEP  = 12;
    localparam int CB    = 3;
    localparam int FRAME = TC * TR;

    localparam logic [8:0] BLK = 9'h000;
    localparam logic [8:0] WHT = 9'h1ff;
    localparam logic [8:0] RED = 9'h1c0;
    localparam logic [8:0] GRN = 9'h038;
    localparam logic [8:0] BLU = 9'h007;

    logic          i_Clk = 1'b0;
    logic          i_Rst = 1'b1;
    logic [2:0]    i_Pattern_Sel = 3'd0;
    logic [9:0]    o_Col_Count;
    logic [9:0]    o_Row_Count;
    logic          o_Frame_Start;
    logic [CB-1:0] o_Red_Video;
    logic [CB-1:0] o_Grn_Video;
    logic [CB-1:0] o_Blu_Video;
    logic [8:0]    rgb;

    int checks   = 0;
    int failures = 0;
    int pos      = 0;
    int seq_err  = 0;

    assign rgb = {o_Red_Video, o_Grn_Video, o_Blu_Video};

    vga_pattern_gen #(
        .COLOR_BITS  (CB),
        .TOTAL_COLS  (TC),
        .TOTAL_ROWS  (TR),
        .ACTIVE_COLS (AC),
        .ACTIVE_ROWS (AR),
        .BAR_STEP    (STEP)
    ) dut (
        .i_Clk         (i_Clk),
        .i_Rst         (i_Rst),
        .i_Pattern_Sel (i_Pattern_Sel),
        .o_Col_Count   (o_Col_Count),
        .o_Row_Count   (o_Row_Count),
        .o_Frame_Start (o_Frame_Start),
        .o_Red_Video   (o_Red_Video),
        .o_Grn_Video   (o_Grn_Video),
        .o_Blu_Video   (o_Blu_Video)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock; the bench tracks the raster position itself and flags any
    // cycle where the counts or the frame strobe disagree with it.
    task automatic step();
        @(posedge i_Clk);
        #1;
        pos = (pos + 1) % FRAME;
        if (o_Frame_Start !== (pos == 0) ||
            o_Col_Count !== 10'(pos % TC) || o_Row_Count !== 10'(pos / TC))
            seq_err++;
    endtask

    task automatic goto_px(input int c, input int r);
        int n;
        n = (r * TC + c - pos + FRAME) % FRAME;
        repeat (n) step();
    endtask

    task automatic next_frame();
        repeat (FRAME - pos) step();
    endtask

    task automatic px(input string tag, input int c, input int r, input logic [8:0] exp);
        goto_px(c, r);
        check(tag, 32'(rgb), 32'(exp));
    endtask

    task automatic do_reset(input int n);
        @(posedge i_Clk);
        #1;
        i_Rst = 1'b1;
        repeat (n) begin
            @(posedge i_Clk);
            #1;
            check("rst_outputs", {o_Col_Count, o_Row_Count, o_Frame_Start, rgb}, 32'd0);
        end
        i_Rst = 1'b0;
        @(posedge i_Clk);
        #1;
        pos = 0;
        check("rel_col", 32'(o_Col_Count), 32'd0);
        check("rel_row", 32'(o_Row_Count), 32'd0);
        check("rel_fs", 32'(o_Frame_Start), 32'd1);
        check("rel_rgb", 32'(rgb), 32'd0);
    endtask

    initial begin
        int nz;

        // Reset and raster sequencing
        do_reset(3);
        px("p0_black", 10, 10, BLK);
        goto_px(TC - 1, 0);
        check("col_last", 32'(o_Col_Count), 32'(TC - 1));
        step();
        check("col_wrap", 32'(o_Col_Count), 32'd0);
        check("row_inc", 32'(o_Row_Count), 32'd1);
        goto_px(TC - 1, TR - 1);
        check("row_last", 32'(o_Row_Count), 32'(TR - 1));
        step();
        check("row_wrap", 32'(o_Row_Count), 32'd0);
        check("fs_period", 32'(o_Frame_Start), 32'd1);
        check("seq_reset", 32'(seq_err), 32'd0);

        // Colour bars
        i_Pattern_Sel = 3'd3;
        next_frame();
        px("bars_c0", 0, 10, BLK);
        px("bars_c11", 11, 10, BLK);
        px("bars_c12", 12, 10, BLU);
        px("bars_c24", 24, 10, GRN);
        px("bars_c48", 48, 10, RED);
        px("bars_c84", 84, 10, WHT);
        px("bars_c95", 95, 10, WHT);
        px("bars_c96", 96, 10, BLK);

        // Checkerboard
        i_Pattern_Sel = 3'd4;
        next_frame();
        px("chk_31_0", 31, 0, BLK);
        px("chk_32_0", 32, 0, WHT);
        px("chk_0_32", 0, 32, WHT);
        px("chk_32_32", 32, 32, BLK);
        px("chk_98_32", 98, 32, BLK);
        goto_px(0, AR);
        nz = 0;
        repeat (TC) begin
            if (rgb !== BLK) nz++;
            step();
        end
        check("chk_row_blank", 32'(nz), 32'd0);

        // Border
        i_Pattern_Sel = 3'd5;
        next_frame();
        px("brd_top", 40, 0, WHT);
        px("brd_left", 0, 10, WHT);
        px("brd_in_l", 1, 10, BLK);
        px("brd_in_r", 94, 10, BLK);
        px("brd_right", 95, 10, WHT);
        px("brd_blank", 96, 10, BLK);
        px("brd_mid", 40, 20, BLK);
        px("brd_bottom", 40, 35, WHT);

        // Reserved code renders black
        i_Pattern_Sel = 3'd7;
        next_frame();
        px("rsvd_a", 10, 10, BLK);
        px("rsvd_b", 50, 20, BLK);

        // Mid-frame select change takes effect only at the next frame
        i_Pattern_Sel = 3'd1;
        next_frame();
        px("mid_white_a", 5, 5, WHT);
        goto_px(0, 20);
        i_Pattern_Sel = 3'd2;
        px("mid_white_b", 5, 25, WHT);
        px("mid_white_c", 40, 35, WHT);
        next_frame();
        check("mid_red_00", 32'(rgb), 32'(RED));
        px("mid_red_b", 40, 20, RED);
        check("seq_patterns", 32'(seq_err), 32'd0);

        // Moving bar; reset mid-frame with a non-zero pattern latched
        i_Pattern_Sel = 3'd6;
        goto_px(30, 10);
        do_reset(2);
        px("mv_f0_a", 5, 0, BLK);
        px("mv_f0_b", 12, 5, BLK);
        next_frame();
        px("mv_f1_11", 11, 5, BLK);
        px("mv_f1_12", 12, 5, WHT);
        px("mv_f1_27", 27, 5, WHT);
        px("mv_f1_28", 28, 5, BLK);
        px("mv_f1_row30", 20, 30, WHT);
        repeat (6) next_frame();
        px("mv_f7_0", 0, 5, BLK);
        px("mv_f7_83", 83, 5, BLK);
        px("mv_f7_84", 84, 5, WHT);
        px("mv_f7_95", 95, 5, WHT);
        px("mv_f7_96", 96, 5, BLK);
        next_frame();
        px("mv_f8_0", 0, 5, WHT);
        px("mv_f8_15", 15, 5, WHT);
        px("mv_f8_16", 16, 5, BLK);
        check("seq_moving", 32'(seq_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
